l1_readout_sequencer: RTL and testbench
=======================================

Name: l1_readout_sequencer

Overview:
- Upstream neighbour of the L1 request counter.
- Accepts L1 trigger accepts, queues them as a pending-trigger count, and issues one single-cycle NewDataReq per queued trigger to start the readout of one event.
- Waits for end-of-event (or a timeout) and a dead-time gap before issuing the next request.
- Pending counter and FSM state are triple-redundant with majority vote, matching the SEU-hardened style of the readout control path.

Parameters:
PEND_W, 4, width of pending-trigger counter
MAX_PEND, 15, saturation value of pending counter (must be <= 2^PEND_W-1)
TO_W, 8, width of event timeout counter
TIMEOUT, 255, cycles in WAIT before forced event end (must be <= 2^TO_W-1)
GAP_CYC, 2, dead-time cycles between event end and next request (>=1)

Ports:
Clk  in  1  system clock, all logic on rising edge except SEU check
Reset  in  1  asynchronous, active-low reset
Trigger  in  1  L1 accept, one pulse per trigger
Stall  in  1  downstream back-pressure; blocks new requests only
EndOfEvent  in  1  readout of current event finished (1-cycle pulse)
NewDataReq  out  1  1-cycle request pulse, drives L1 request counter
Pending  out  PEND_W  voted pending-trigger count
ReadActive  out  1  high in states REQ and WAIT
Overflow  out  1  1-cycle pulse when a trigger is dropped
Timeout  out  1  1-cycle pulse when WAIT expires without EndOfEvent
SeuError  out  1  redundant copies disagree

Behaviour:
- Reset (Reset=0, async): all three copies of Pending=0 and state=IDLE; timers=0; every output 0. Reset mid-event discards the event and all pending triggers.
- Pending counter, voted value P:
  - Trigger only: P+1, unless P==MAX_PEND; then P is unchanged and Overflow pulses for the following cycle.
  - Request issued only (edge leaving REQ): P-1.
  - Both on the same edge: P unchanged, no Overflow, even at MAX_PEND.
  - Never wraps below 0; decrement only occurs from REQ, and REQ is entered only with P>0.
- FSM (3 copies; each copy loads next state computed from the voted state):
  - IDLE: P>0 and Stall=0 -> REQ; otherwise stay.
  - REQ: NewDataReq=1 for exactly this cycle; -> WAIT unconditionally; clear timeout counter.
  - WAIT: EndOfEvent=1 -> GAP. Timeout counter reaches TIMEOUT -> GAP with Timeout=1 for one cycle. Timeout counter otherwise increments.
  - GAP: count GAP_CYC cycles -> IDLE.
- EndOfEvent outside WAIT is ignored. Stall is ignored once in REQ, WAIT or GAP.
- Latency:
  - Trigger sampled at edge k in IDLE with P=0: Pending=1 after edge k.
  - NewDataReq high between edges k+1 and k+2.
  - Pending=0 after edge k+2.
- Minimum request spacing: 1 (REQ) + 1 (WAIT, if EndOfEvent arrives immediately) + GAP_CYC + 1 (IDLE) cycles.
- All outputs are registered or decoded from the voted state only; no combinational path from inputs to outputs.
- SeuError: sampled on falling edge of Clk. It is 1 when any bit of the three Pending copies or the three state copies differs, else 0. Majority vote corrects a single upset on the next rising edge.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: IDLE=2'b00, REQ=2'b01, WAIT=2'b11, GAP=2'b10, Gray order.
  - Default values of PEND_W, MAX_PEND, TIMEOUT, GAP_CYC.
- One natural sub-module: tmr_vote, a parameterised-width bitwise 2-of-3 majority voter plus mismatch flag. It is instantiated for the Pending copies and for the state copies.

Test Plan:
- Reset released; single Trigger at cycle 5; EndOfEvent 3 cycles after NewDataReq -> Pending 0->1->0, one NewDataReq at cycle 7, ReadActive cycles 7-10, next IDLE after GAP_CYC=2.
- 16 Triggers back-to-back with Stall=1 -> Pending saturates at 15, Overflow pulses once (16th trigger), no NewDataReq. Release Stall -> 15 NewDataReq pulses in total.
- Trigger coincident with REQ exit edge, P=3 -> P stays 3, no Overflow.
- No EndOfEvent after request -> Timeout pulses exactly 256 cycles after NewDataReq (TIMEOUT=255 plus transition), then GAP, then next request if P>0.
- Force-flip one Pending copy bit and one state copy bit -> SeuError=1 at next falling edge, voted outputs unchanged, SeuError back to 0 after the following rising edge.
- Assert Reset in WAIT with P=5 -> all outputs 0 immediately (async), Pending=0, no NewDataReq after release until a new Trigger.

Source files
------------

// File: rtl/l1_readout_sequencer_pkg.sv
// Shared definitions for the L1 readout sequencer: default sizing and the
// Gray-ordered FSM encoding used by every redundant state copy.
package l1_readout_sequencer_pkg;

  localparam int PEND_W_DEF   = 4;
  localparam int MAX_PEND_DEF = 15;
  localparam int TO_W_DEF     = 8;
  localparam int TIMEOUT_DEF  = 255;
  localparam int GAP_CYC_DEF  = 2;

  // Gray order: the normal IDLE->REQ->WAIT->GAP->IDLE walk flips one bit per step.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b11,
    GAP  = 2'b10
  } state_e;

  // REQ and WAIT are exactly the states with bit 0 set.
  function automatic logic is_read_active(input state_e s);
    return s[0];
  endfunction

endpackage

// File: rtl/l1_readout_sequencer_tmr_vote.sv
// Bitwise 2-of-3 majority voter with a flag raised whenever any copy
// disagrees with the others.
module l1_readout_sequencer_tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y,
  output logic         mismatch
);

  assign y        = (a & b) | (a & c) | (b & c);
  assign mismatch = |((a ^ b) | (a ^ c));

endmodule

// File: rtl/l1_readout_sequencer.sv
// Turns L1 trigger accepts into a queue of single-cycle NewDataReq pulses,
// one per event, with triple-redundant pending count and FSM state.
module l1_readout_sequencer
  import l1_readout_sequencer_pkg::*;
#(
  parameter int PEND_W   = PEND_W_DEF,
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int TO_W     = TO_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Trigger,
  input  logic              Stall,
  input  logic              EndOfEvent,
  output logic              NewDataReq,
  output logic [PEND_W-1:0] Pending,
  output logic              ReadActive,
  output logic              Overflow,
  output logic              Timeout,
  output logic              SeuError
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  // Protocol: Trigger and EndOfEvent are single-cycle pulses sampled on the
  // rising edge; NewDataReq is a single-cycle pulse with no acknowledge.
  // Stall only holds the FSM in IDLE, it never cancels a request in flight.

  logic [PEND_W-1:0] pend0_q, pend1_q, pend2_q;
  logic [PEND_W-1:0] pend_d, pend_v;
  logic [1:0]        state0_q, state1_q, state2_q;
  logic [1:0]        state_raw;
  state_e            state_d, state_v;
  logic [TO_W-1:0]   tcnt_q, tcnt_d, tcnt_inc;
  logic [GAP_W-1:0]  gcnt_q, gcnt_d;
  logic              ovf_q, ovf_d;
  logic              to_q, to_d;
  logic              seu_q, seu_d;
  logic              pend_mis, state_mis;
  logic              req_exit;

  l1_readout_sequencer_tmr_vote #(.W(PEND_W)) u_vote_pend (
    .a        (pend0_q),
    .b        (pend1_q),
    .c        (pend2_q),
    .y        (pend_v),
    .mismatch (pend_mis)
  );

  l1_readout_sequencer_tmr_vote #(.W(2)) u_vote_state (
    .a        (state0_q),
    .b        (state1_q),
    .c        (state2_q),
    .y        (state_raw),
    .mismatch (state_mis)
  );

  assign state_v = state_e'(state_raw);

  // Every copy reloads from the voted value, which scrubs a single upset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pend0_q  <= '0;
      pend1_q  <= '0;
      pend2_q  <= '0;
      state0_q <= IDLE;
      state1_q <= IDLE;
      state2_q <= IDLE;
      tcnt_q   <= '0;
      gcnt_q   <= '0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      pend0_q  <= pend_d;
      pend1_q  <= pend_d;
      pend2_q  <= pend_d;
      state0_q <= state_d;
      state1_q <= state_d;
      state2_q <= state_d;
      tcnt_q   <= tcnt_d;
      gcnt_q   <= gcnt_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
    end
  end

  always_ff @(negedge Clk or negedge Reset) begin
    if (!Reset) seu_q <= 1'b0;
    else        seu_q <= seu_d;
  end

  always_comb begin
    state_d  = state_v;
    tcnt_d   = tcnt_q;
    gcnt_d   = '0;
    to_d     = 1'b0;
    tcnt_inc = tcnt_q + 1'b1;
    case (state_v)
      IDLE: if ((pend_v != '0) && !Stall) state_d = REQ;
      REQ: begin
        state_d = WAIT;
        tcnt_d  = '0;
      end
      WAIT: begin
        if (EndOfEvent) begin
          state_d = GAP;
        end else if (tcnt_inc == TO_W'(TIMEOUT)) begin
          state_d = GAP;
          to_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      GAP: begin
        if (gcnt_q == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
        else                               gcnt_d  = gcnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A trigger landing on the REQ exit edge cancels the decrement, so no
  // overflow is possible on that edge even when saturated.
  always_comb begin
    req_exit = (state_v == REQ);
    pend_d   = pend_v;
    ovf_d    = 1'b0;
    seu_d    = pend_mis | state_mis;
    if (Trigger && !req_exit) begin
      if (pend_v == PEND_W'(MAX_PEND)) ovf_d  = 1'b1;
      else                             pend_d = pend_v + 1'b1;
    end else if (!Trigger && req_exit) begin
      pend_d = pend_v - 1'b1;
    end
  end

  always_comb begin
    NewDataReq = (state_v == REQ);
    ReadActive = is_read_active(state_v);
    Pending    = pend_v;
    Overflow   = ovf_q;
    Timeout    = to_q;
    SeuError   = seu_q;
  end

endmodule

// File: tb/tb_l1_readout_sequencer.sv
// Directed bench for l1_readout_sequencer: request latency, saturation,
// coincident trigger/request, timeout, upset scrubbing and async reset.
module tb_l1_readout_sequencer;

  localparam int PEND_W = 4;

  logic              Clk, Reset, Trigger, Stall, EndOfEvent;
  logic              NewDataReq, ReadActive, Overflow, Timeout, SeuError;
  logic [PEND_W-1:0] Pending;

  int n_tests, n_fail, cyc;
  int req_cnt, ovf_cnt, to_cnt;
  int r0, o0, t0, n, nreq, last;
  logic [3:0] flip_p;
  logic [1:0] flip_s;

  l1_readout_sequencer #(
    .PEND_W(4), .MAX_PEND(15), .TO_W(8), .TIMEOUT(255), .GAP_CYC(2)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Trigger    (Trigger),
    .Stall      (Stall),
    .EndOfEvent (EndOfEvent),
    .NewDataReq (NewDataReq),
    .Pending    (Pending),
    .ReadActive (ReadActive),
    .Overflow   (Overflow),
    .Timeout    (Timeout),
    .SeuError   (SeuError)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // pulse counters, sampled mid-cycle
  always @(negedge Clk) begin
    if (Reset) begin
      if (NewDataReq) req_cnt++;
      if (Overflow)   ovf_cnt++;
      if (Timeout)    to_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Reset = 1'b0; Trigger = 1'b0; Stall = 1'b0; EndOfEvent = 1'b0;
    repeat (2) tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic coincide(input int p);
    automatic int ov0;
    do_reset();
    ov0 = ovf_cnt;
    Stall = 1'b1; Trigger = 1'b1;
    repeat (p) tick();
    Trigger = 1'b0; Stall = 1'b0;
    tick();
    check($sformatf("t3_req_p%0d", p), NewDataReq, 1);
    check($sformatf("t3_pend_req_p%0d", p), Pending, p);
    Trigger = 1'b1;
    tick();
    Trigger = 1'b0;
    check($sformatf("t3_pend_coinc_p%0d", p), Pending, p);
    tick();
    check($sformatf("t3_no_ovf_p%0d", p), ovf_cnt - ov0, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    req_cnt = 0; ovf_cnt = 0; to_cnt = 0;
    Reset = 1'b0; Trigger = 1'b0; Stall = 1'b0; EndOfEvent = 1'b0;
    repeat (2) tick();

    // reset state
    check("rst_pending", Pending, 0);
    check("rst_req", NewDataReq, 0);
    check("rst_active", ReadActive, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_timeout", Timeout, 0);
    check("rst_seu", SeuError, 0);
    Reset = 1'b1;
    tick();

    // single trigger, EndOfEvent three cycles after the request
    r0 = req_cnt;
    Trigger = 1'b1; tick(); Trigger = 1'b0;
    check("t1_pend_after_trig", Pending, 1);
    check("t1_req_idle", NewDataReq, 0);
    tick();
    check("t1_req_pulse", NewDataReq, 1);
    check("t1_active_req", ReadActive, 1);
    tick();
    check("t1_pend_after_req", Pending, 0);
    check("t1_req_end", NewDataReq, 0);
    check("t1_active_wait", ReadActive, 1);
    tick(); tick();
    check("t1_active_wait3", ReadActive, 1);
    EndOfEvent = 1'b1; tick(); EndOfEvent = 1'b0;
    check("t1_gap_inactive", ReadActive, 0);
    repeat (5) tick();
    check("t1_req_count", req_cnt - r0, 1);

    // saturation under Stall, then drain with EndOfEvent held high
    do_reset();
    r0 = req_cnt; o0 = ovf_cnt;
    Stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      Trigger = 1'b1;
      tick();
      if (i == 14) begin
        check("t2_pend_15", Pending, 15);
        check("t2_no_ovf_yet", Overflow, 0);
      end
    end
    Trigger = 1'b0;
    check("t2_ovf_pulse", Overflow, 1);
    check("t2_pend_sat", Pending, 15);
    tick();
    check("t2_ovf_end", Overflow, 0);
    check("t2_ovf_count", ovf_cnt - o0, 1);
    check("t2_no_req_stalled", req_cnt - r0, 0);
    Stall = 1'b0; EndOfEvent = 1'b1;
    nreq = 0; last = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (NewDataReq) begin
        if (nreq == 0) check("t2_first_req", i, 0);
        else           check("t2_req_spacing", i - last, 5);
        last = i;
        nreq++;
      end
    end
    EndOfEvent = 1'b0;
    check("t2_req_total", nreq, 15);
    check("t2_pend_drained", Pending, 0);

    // trigger on the REQ exit edge, mid-range and saturated
    coincide(3);
    coincide(15);

    // timeout without EndOfEvent
    do_reset();
    t0 = to_cnt;
    Stall = 1'b1; Trigger = 1'b1;
    repeat (2) tick();
    Trigger = 1'b0; Stall = 1'b0;
    n = 0;
    while (!NewDataReq && n < 20) begin tick(); n++; end
    check("t4_req_seen", NewDataReq, 1);
    n = 0;
    while (!Timeout && n < 400) begin tick(); n++; end
    check("t4_timeout_lat", n, 256);
    check("t4_gap_inactive", ReadActive, 0);
    check("t4_pend_left", Pending, 1);
    n = 0;
    while (!NewDataReq && n < 20) begin tick(); n++; end
    check("t4_next_req_lat", n, 3);
    check("t4_timeout_count", to_cnt - t0, 1);

    // single upsets in one pending copy and one state copy
    do_reset();
    Stall = 1'b1; Trigger = 1'b1;
    repeat (5) tick();
    Trigger = 1'b0;
    check("t5_seu_clean", SeuError, 0);
    flip_p = dut.pend1_q ^ 4'b0100;
    flip_s = dut.state2_q ^ 2'b01;
    force dut.pend1_q = flip_p;
    force dut.state2_q = flip_s;
    @(negedge Clk); #1;
    check("t5_seu_set", SeuError, 1);
    check("t5_pend_voted", Pending, 5);
    check("t5_active_voted", ReadActive, 0);
    check("t5_req_voted", NewDataReq, 0);
    release dut.pend1_q;
    release dut.state2_q;
    tick();
    check("t5_seu_hold", SeuError, 1);
    check("t5_pend_after_scrub", Pending, 5);
    @(negedge Clk); #1;
    check("t5_seu_clear", SeuError, 0);

    // asynchronous reset while in WAIT with five triggers queued
    do_reset();
    Stall = 1'b1; Trigger = 1'b1;
    repeat (6) tick();
    Trigger = 1'b0; Stall = 1'b0;
    tick();
    tick();
    check("t6_active_wait", ReadActive, 1);
    check("t6_pend_5", Pending, 5);
    #2; Reset = 1'b0; #1;
    check("t6_rst_pend", Pending, 0);
    check("t6_rst_active", ReadActive, 0);
    check("t6_rst_req", NewDataReq, 0);
    check("t6_rst_ovf", Overflow, 0);
    check("t6_rst_timeout", Timeout, 0);
    tick(); tick();
    Reset = 1'b1;
    r0 = req_cnt;
    repeat (20) tick();
    check("t6_no_req_after_rst", req_cnt - r0, 0);
    check("t6_pend_after_rst", Pending, 0);
    Trigger = 1'b1; tick(); Trigger = 1'b0;
    repeat (3) tick();
    check("t6_req_new_trig", req_cnt - r0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
